fsm_datapath: RTL and testbench
===============================

# fsm_datapath

Register-and-ALU datapath sitting directly downstream of the six-state sequencing controller. It consumes the controller's CLR, W, CE, SEL and S outputs cycle by cycle. It loads two operand registers, computes into an accumulator through a selectable-operand ALU, and stores results into an 8-entry register file. Result, flags and register-file readback are exposed for the board display and the bench.

## Interface
- WIDTH, 8, data width of operands, accumulator and register-file entries (≥4)
- CLK  in  1  system clock, all state updates on rising edge
- RESET_N  in  1  asynchronous, active-low reset
- CLR  in  1  synchronous clear of RA, RB, RD and flags
- W  in  3  register-file address (write and read)
- CE  in  4  clock enables: [0] RA, [1] RB, [2] RF write, [3] RD
- SEL  in  2  ALU operand-A select
- S  in  3  ALU opcode
- DIN_A  in  WIDTH  external operand A
- DIN_B  in  WIDTH  external operand B
- DOUT  out  WIDTH  accumulator RD
- RF_DOUT  out  WIDTH  register-file entry at W, combinational read
- ZERO  out  1  registered: last RD load was zero
- CARRY  out  1  registered: carry/borrow of last RD load
- WR_CNT  out  4  saturating count of RF writes since reset/CLR

## Operation
- RA <= DIN_A when CE[0]; RB <= DIN_B when CE[1].
- Operand A mux, by SEL: 00 RA, 01 RD, 10 RB, 11 RF[W]. Operand B is always RB.
- ALU op, by S:
  - 000 A
  - 001 A+B
  - 010 A−B
  - 011 A&B
  - 100 A|B
  - 101 A^B
  - 110 A<<1
  - 111 ~A
- ALU computes WIDTH+1 bits. The result is truncated to WIDTH. Bit WIDTH is carry for add, borrow for subtract, and the shifted-out MSB for shift. It is 0 for all other ops.
- When CE[3]: RD <= result, ZERO <= (result==0), CARRY <= bit WIDTH.
- When CE[2]: RF[W] <= RD, using the pre-edge RD. WR_CNT increments and saturates at 15.
- SEL and S are don't-care whenever CE[3]=0. Undriven or latched controller values in write states must not disturb state.
- Multiple CE bits set in one cycle: all act in parallel on pre-edge values. CE[2]&CE[3] stores the old RD. CE[0]&CE[3] with SEL=00 uses the old RA.
- CLR=1 overrides every CE for RA, RB, RD, ZERO, CARRY and WR_CNT, forcing all to 0. CLR does not clear the register file; CE[2] writes are suppressed during CLR.
- Reset values: RA, RB, RD, all RF entries, ZERO, CARRY and WR_CNT are 0. Therefore DOUT=0, RF_DOUT=0, ZERO=0 and CARRY=0.

## Timing
- All registered outputs change one cycle after the CE/CLR cycle that loads them. RF_DOUT follows W combinationally, and also follows a completed write at the next edge.
- One controller pass (clear, load, op, op, write, write) takes 6 cycles. RF[W] is valid from the edge ending the first write state. The second write state rewrites the same value.
- RESET_N assertion mid-sequence clears everything immediately, independent of CLK. Deassertion is synchronised by the system and needs no handling here.
- No handshake; every enable acts exactly in its own cycle.

## Structure
- Shared package fsm_dp_pkg holds:
  - the S opcode constants
  - the SEL codes
  - CE bit indices (CE_RA=0, CE_RB=1, CE_RF=2, CE_RD=3)
  - the RF depth constant (8)
- One natural sub-module: dp_alu. It is combinational, parameterised by WIDTH, and takes A, B and S to produce a WIDTH+1-bit result.
- Registers, mux, register file and counter stay in fsm_datapath.

## Test plan
- Reset then release, DIN_A=8'h35, DIN_B=8'h12, drive the standard 6-state pattern:
  - after the load state: RA=35, RB=12
  - after S=010: RD=23, CARRY=0
  - after SEL=01/S=001: RD=35
  - after the write states: RF[4]=35, WR_CNT=2
- Borrow and zero: RA=05, RB=07, S=010 → RD=FE, CARRY=1. Then RA=07, S=010 → RD=00, ZERO=1, CARRY=0.
- Simultaneous CE=4'b1100 with RD=35, W=3, S=000/SEL=10 → RF[3]=35 (old value) and RD=12.
- CLR with CE=4'b1111 in the same cycle → RA, RB, RD and WR_CNT are 0, and RF[W] is unchanged.
- Assert RESET_N low between clock edges mid-sequence → all outputs 0 immediately. RF[4], previously 35, reads 0.
- 16 consecutive writes → WR_CNT saturates at 15. Sweep W 0–7 and check RF_DOUT tracks each stored value.

Source files
------------

// File: rtl/fsm_dp_pkg.sv
// Shared constants for the sequencing-controller datapath: ALU opcodes, operand-A
// select codes, clock-enable bit positions and register-file geometry.
package fsm_dp_pkg;

    typedef enum logic [2:0] {
        OP_PASS = 3'b000,
        OP_ADD  = 3'b001,
        OP_SUB  = 3'b010,
        OP_AND  = 3'b011,
        OP_OR   = 3'b100,
        OP_XOR  = 3'b101,
        OP_SHL  = 3'b110,
        OP_NOT  = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        SEL_RA = 2'b00,
        SEL_RD = 2'b01,
        SEL_RB = 2'b10,
        SEL_RF = 2'b11
    } sel_e;

    localparam int CE_RA = 0;
    localparam int CE_RB = 1;
    localparam int CE_RF = 2;
    localparam int CE_RD = 3;

    localparam int RF_DEPTH = 8;
    localparam int RF_AW    = $clog2(RF_DEPTH);

    localparam logic [3:0] WR_CNT_MAX = 4'hF;

endpackage

// File: rtl/fsm_dp_if.sv
// Controller-to-datapath bundle: control/operand inputs from the controller side,
// result, flags and readback back towards the display and bench.
interface fsm_dp_if
    import fsm_dp_pkg::*;
#(
    parameter int WIDTH = 8
);
    logic               CLR;
    logic [RF_AW-1:0]   W;
    logic [3:0]         CE;
    logic [1:0]         SEL;
    logic [2:0]         S;
    logic [WIDTH-1:0]   DIN_A;
    logic [WIDTH-1:0]   DIN_B;
    logic [WIDTH-1:0]   DOUT;
    logic [WIDTH-1:0]   RF_DOUT;
    logic               ZERO;
    logic               CARRY;
    logic [3:0]         WR_CNT;

    modport master (
        output CLR, W, CE, SEL, S, DIN_A, DIN_B,
        input  DOUT, RF_DOUT, ZERO, CARRY, WR_CNT
    );

    modport slave (
        input  CLR, W, CE, SEL, S, DIN_A, DIN_B,
        output DOUT, RF_DOUT, ZERO, CARRY, WR_CNT
    );
endinterface

// File: rtl/dp_alu.sv
// Combinational ALU producing a WIDTH+1 result; the top bit is carry, borrow or the
// bit shifted out, and zero for the logical/pass ops.
module dp_alu
    import fsm_dp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       S,
    output logic [WIDTH:0]   RESULT
);

    always_comb begin
        // NOTE: default assignment first so no path through the case can infer a latch.
        RESULT = '0;
        case (alu_op_e'(S))
            OP_PASS: RESULT = {1'b0, A};
            OP_ADD:  RESULT = {1'b0, A} + {1'b0, B};
            // Wrap of the extended subtraction sets the top bit exactly when A < B.
            OP_SUB:  RESULT = {1'b0, A} - {1'b0, B};
            OP_AND:  RESULT = {1'b0, A & B};
            OP_OR:   RESULT = {1'b0, A | B};
            OP_XOR:  RESULT = {1'b0, A ^ B};
            OP_SHL:  RESULT = {A, 1'b0};
            OP_NOT:  RESULT = {1'b0, ~A};
            default: RESULT = '0;
        endcase
    end

endmodule

// File: rtl/fsm_datapath.sv
// Operand registers, accumulator, flags and an 8-entry register file driven cycle by
// cycle by the six-state sequencing controller's CLR/W/CE/SEL/S outputs.
module fsm_datapath
    import fsm_dp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic     CLK,
    input  logic     RESET_N,
    fsm_dp_if.slave  bus
);

    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [WIDTH-1:0] rd;
    logic             zero_q;
    logic             carry_q;
    logic [3:0]       wr_cnt;
    logic [WIDTH-1:0] rf [RF_DEPTH];

    logic [WIDTH-1:0] op_a;
    logic [WIDTH:0]   alu_res;

    always_comb begin
        op_a = ra;
        case (sel_e'(bus.SEL))
            SEL_RA:  op_a = ra;
            SEL_RD:  op_a = rd;
            SEL_RB:  op_a = rb;
            SEL_RF:  op_a = rf[bus.W];
            default: op_a = ra;
        endcase
    end

    dp_alu #(.WIDTH(WIDTH)) u_alu (
        .A      (op_a),
        .B      (rb),
        .S      (bus.S),
        .RESULT (alu_res)
    );

    // NOTE: non-blocking assignments let every enable in a cycle act on pre-edge
    // values, so CE[2]&CE[3] stores the old RD and CE[0]&CE[3] uses the old RA.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ra      <= '0;
            rb      <= '0;
            rd      <= '0;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
            wr_cnt  <= '0;
            // NOTE: the register file is reset too, because readback must show 0
            // after reset; this keeps it as flops rather than an unreset RAM.
            for (int i = 0; i < RF_DEPTH; i++) rf[i] <= '0;
        end else if (bus.CLR) begin
            // CLR leaves the register file alone and suppresses any write to it.
            ra      <= '0;
            rb      <= '0;
            rd      <= '0;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
            wr_cnt  <= '0;
        end else begin
            if (bus.CE[CE_RA]) ra <= bus.DIN_A;
            if (bus.CE[CE_RB]) rb <= bus.DIN_B;
            if (bus.CE[CE_RF]) begin
                rf[bus.W] <= rd;
                if (wr_cnt != WR_CNT_MAX) wr_cnt <= wr_cnt + 4'd1;
            end
            if (bus.CE[CE_RD]) begin
                rd      <= alu_res[WIDTH-1:0];
                zero_q  <= (alu_res[WIDTH-1:0] == '0);
                carry_q <= alu_res[WIDTH];
            end
        end
    end

    assign bus.DOUT    = rd;
    assign bus.RF_DOUT = rf[bus.W];
    assign bus.ZERO    = zero_q;
    assign bus.CARRY   = carry_q;
    assign bus.WR_CNT  = wr_cnt;

endmodule

// File: tb/tb_fsm_datapath.sv
// Bench for fsm_datapath: directed controller passes plus randomized cycles checked
// against an arithmetic reference model of the register/ALU behaviour.
module tb_fsm_datapath;

    localparam int WIDTH = 8;
    localparam int MASK  = (1 << WIDTH) - 1;

    logic CLK;
    logic RESET_N;

    fsm_dp_if #(.WIDTH(WIDTH)) dp_bus ();

    fsm_datapath #(.WIDTH(WIDTH)) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (dp_bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: plain integers holding architectural state.
    int m_ra, m_rb, m_rd, m_zero, m_carry, m_cnt;
    int m_rf [8];

    function automatic void model_reset();
        m_ra = 0; m_rb = 0; m_rd = 0; m_zero = 0; m_carry = 0; m_cnt = 0;
        for (int i = 0; i < 8; i++) m_rf[i] = 0;
    endfunction

    function automatic void model_step(input bit clr, input bit [3:0] ce, input int w,
                                       input int sel, input int s, input int a, input int b);
        int opa;
        int r;
        int c;
        if (clr) begin
            m_ra = 0; m_rb = 0; m_rd = 0; m_zero = 0; m_carry = 0; m_cnt = 0;
            return;
        end
        opa = (sel == 0) ? m_ra : (sel == 1) ? m_rd : (sel == 2) ? m_rb : m_rf[w];
        c = 0;
        case (s)
            0: r = opa;
            1: begin r = opa + m_rb; c = (r > MASK) ? 1 : 0; r = r % (MASK + 1); end
            2: begin r = opa - m_rb; c = (r < 0) ? 1 : 0; if (r < 0) r = r + MASK + 1; end
            3: r = opa & m_rb;
            4: r = opa | m_rb;
            5: r = opa ^ m_rb;
            6: begin r = opa * 2; c = (r > MASK) ? 1 : 0; r = r % (MASK + 1); end
            default: r = MASK - opa;
        endcase
        if (ce[2]) begin
            m_rf[w] = m_rd;
            if (m_cnt < 15) m_cnt = m_cnt + 1;
        end
        if (ce[3]) begin
            m_rd = r;
            m_zero = (r == 0) ? 1 : 0;
            m_carry = c;
        end
        if (ce[0]) m_ra = a;
        if (ce[1]) m_rb = b;
    endfunction

    // Drive one controller cycle at the falling edge, let the rising edge act, settle.
    task automatic step(input bit clr, input bit [3:0] ce, input bit [2:0] w,
                        input bit [1:0] sel, input bit [2:0] s,
                        input bit [7:0] a, input bit [7:0] b);
        @(negedge CLK);
        dp_bus.CLR   = clr;
        dp_bus.CE    = ce;
        dp_bus.W     = w;
        dp_bus.SEL   = sel;
        dp_bus.S     = s;
        dp_bus.DIN_A = a;
        dp_bus.DIN_B = b;
        @(posedge CLK);
        model_step(clr, ce, int'(w), int'(sel), int'(s), int'(a), int'(b));
        #1;
    endtask

    task automatic test_reset();
        RESET_N = 1'b0;
        dp_bus.CLR = 1'b0; dp_bus.CE = 4'b0000; dp_bus.W = 3'd4; dp_bus.SEL = 2'b00;
        dp_bus.S = 3'b000; dp_bus.DIN_A = 8'h00; dp_bus.DIN_B = 8'h00;
        model_reset();
        repeat (3) @(posedge CLK);
        #1;
        n_tests++;
        if (dp_bus.DOUT !== 8'h00 || dp_bus.RF_DOUT !== 8'h00 || dp_bus.ZERO !== 1'b0 ||
            dp_bus.CARRY !== 1'b0 || dp_bus.WR_CNT !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_state: DOUT=%h RF_DOUT=%h ZERO=%b CARRY=%b WR_CNT=%0d, want all 0",
                     dp_bus.DOUT, dp_bus.RF_DOUT, dp_bus.ZERO, dp_bus.CARRY, dp_bus.WR_CNT);
        end
        @(negedge CLK);
        RESET_N = 1'b1;
    endtask

    task automatic test_standard_pass();
        step(1'b1, 4'b0000, 3'd4, 2'b00, 3'b000, 8'h35, 8'h12);
        step(1'b0, 4'b0011, 3'd4, 2'b00, 3'b000, 8'h35, 8'h12);
        n_tests++;
        if (dp_bus.DOUT !== 8'h00) begin
            n_fail++;
            $display("FAIL pass_load: DOUT=%h want 00", dp_bus.DOUT);
        end
        step(1'b0, 4'b1000, 3'd4, 2'b00, 3'b010, 8'h35, 8'h12);
        n_tests++;
        if (dp_bus.DOUT !== 8'h23 || dp_bus.CARRY !== 1'b0 || dp_bus.ZERO !== 1'b0) begin
            n_fail++;
            $display("FAIL pass_sub: DOUT=%h CARRY=%b ZERO=%b want 23/0/0",
                     dp_bus.DOUT, dp_bus.CARRY, dp_bus.ZERO);
        end
        step(1'b0, 4'b1000, 3'd4, 2'b01, 3'b001, 8'h35, 8'h12);
        n_tests++;
        if (dp_bus.DOUT !== 8'h35 || dp_bus.CARRY !== 1'b0) begin
            n_fail++;
            $display("FAIL pass_add: DOUT=%h CARRY=%b want 35/0", dp_bus.DOUT, dp_bus.CARRY);
        end
        // SEL/S are junk in the write states and must not matter.
        step(1'b0, 4'b0100, 3'd4, 2'($urandom), 3'($urandom), 8'h35, 8'h12);
        n_tests++;
        if (dp_bus.RF_DOUT !== 8'h35 || dp_bus.WR_CNT !== 4'd1 || dp_bus.DOUT !== 8'h35) begin
            n_fail++;
            $display("FAIL pass_write1: RF_DOUT=%h WR_CNT=%0d DOUT=%h want 35/1/35",
                     dp_bus.RF_DOUT, dp_bus.WR_CNT, dp_bus.DOUT);
        end
        step(1'b0, 4'b0100, 3'd4, 2'($urandom), 3'($urandom), 8'h35, 8'h12);
        n_tests++;
        if (dp_bus.RF_DOUT !== 8'h35 || dp_bus.WR_CNT !== 4'd2) begin
            n_fail++;
            $display("FAIL pass_write2: RF_DOUT=%h WR_CNT=%0d want 35/2",
                     dp_bus.RF_DOUT, dp_bus.WR_CNT);
        end
    endtask

    task automatic test_borrow_zero();
        step(1'b0, 4'b0011, 3'd0, 2'b00, 3'b000, 8'h05, 8'h07);
        step(1'b0, 4'b1000, 3'd0, 2'b00, 3'b010, 8'h05, 8'h07);
        n_tests++;
        if (dp_bus.DOUT !== 8'hFE || dp_bus.CARRY !== 1'b1 || dp_bus.ZERO !== 1'b0) begin
            n_fail++;
            $display("FAIL borrow: DOUT=%h CARRY=%b ZERO=%b want FE/1/0",
                     dp_bus.DOUT, dp_bus.CARRY, dp_bus.ZERO);
        end
        step(1'b0, 4'b0001, 3'd0, 2'b00, 3'b000, 8'h07, 8'h07);
        step(1'b0, 4'b1000, 3'd0, 2'b00, 3'b010, 8'h07, 8'h07);
        n_tests++;
        if (dp_bus.DOUT !== 8'h00 || dp_bus.CARRY !== 1'b0 || dp_bus.ZERO !== 1'b1) begin
            n_fail++;
            $display("FAIL zero: DOUT=%h CARRY=%b ZERO=%b want 00/0/1",
                     dp_bus.DOUT, dp_bus.CARRY, dp_bus.ZERO);
        end
        // Shift-left carry is the MSB shifted out: 0x81 << 1 = 0x02, carry 1.
        step(1'b0, 4'b0001, 3'd0, 2'b00, 3'b000, 8'h81, 8'h07);
        step(1'b0, 4'b1000, 3'd0, 2'b00, 3'b110, 8'h81, 8'h07);
        n_tests++;
        if (dp_bus.DOUT !== 8'h02 || dp_bus.CARRY !== 1'b1) begin
            n_fail++;
            $display("FAIL shift_carry: DOUT=%h CARRY=%b want 02/1", dp_bus.DOUT, dp_bus.CARRY);
        end
    endtask

    task automatic test_simultaneous();
        step(1'b0, 4'b0011, 3'd3, 2'b00, 3'b000, 8'h35, 8'h12);
        step(1'b0, 4'b1000, 3'd3, 2'b00, 3'b000, 8'h35, 8'h12);
        step(1'b0, 4'b1100, 3'd3, 2'b10, 3'b000, 8'h35, 8'h12);
        n_tests++;
        if (dp_bus.RF_DOUT !== 8'h35 || dp_bus.DOUT !== 8'h12) begin
            n_fail++;
            $display("FAIL ce_rf_rd: RF_DOUT=%h DOUT=%h want 35/12", dp_bus.RF_DOUT, dp_bus.DOUT);
        end
        step(1'b0, 4'b1001, 3'd3, 2'b00, 3'b000, 8'hA7, 8'h12);
        n_tests++;
        if (dp_bus.DOUT !== 8'h35) begin
            n_fail++;
            $display("FAIL ce_ra_rd_old: DOUT=%h want 35", dp_bus.DOUT);
        end
        step(1'b0, 4'b1000, 3'd3, 2'b00, 3'b000, 8'h00, 8'h00);
        n_tests++;
        if (dp_bus.DOUT !== 8'hA7) begin
            n_fail++;
            $display("FAIL ce_ra_new: DOUT=%h want A7", dp_bus.DOUT);
        end
    endtask

    task automatic test_clr();
        // RF[4] holds 35 and RD holds A7, so a leaked write would be visible.
        step(1'b1, 4'b1111, 3'd4, 2'b00, 3'b001, 8'h5A, 8'h66);
        n_tests++;
        if (dp_bus.DOUT !== 8'h00 || dp_bus.WR_CNT !== 4'd0 || dp_bus.ZERO !== 1'b0 ||
            dp_bus.CARRY !== 1'b0 || dp_bus.RF_DOUT !== 8'h35) begin
            n_fail++;
            $display("FAIL clr_override: DOUT=%h WR_CNT=%0d ZERO=%b CARRY=%b RF_DOUT=%h want 00/0/0/0/35",
                     dp_bus.DOUT, dp_bus.WR_CNT, dp_bus.ZERO, dp_bus.CARRY, dp_bus.RF_DOUT);
        end
        // RA + RB after CLR must be 0 + 0.
        step(1'b0, 4'b1000, 3'd4, 2'b00, 3'b001, 8'h5A, 8'h66);
        n_tests++;
        if (dp_bus.DOUT !== 8'h00 || dp_bus.ZERO !== 1'b1 || dp_bus.CARRY !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_ra_rb: DOUT=%h ZERO=%b CARRY=%b want 00/1/0",
                     dp_bus.DOUT, dp_bus.ZERO, dp_bus.CARRY);
        end
    endtask

    task automatic test_async_reset();
        test_standard_pass();
        @(negedge CLK);
        dp_bus.CLR = 1'b0; dp_bus.CE = 4'b1000; dp_bus.W = 3'd4;
        dp_bus.SEL = 2'b01; dp_bus.S = 3'b111;
        #2;
        RESET_N = 1'b0;
        #1;
        model_reset();
        n_tests++;
        if (dp_bus.DOUT !== 8'h00 || dp_bus.RF_DOUT !== 8'h00 || dp_bus.ZERO !== 1'b0 ||
            dp_bus.CARRY !== 1'b0 || dp_bus.WR_CNT !== 4'd0) begin
            n_fail++;
            $display("FAIL async_reset: DOUT=%h RF_DOUT=%h ZERO=%b CARRY=%b WR_CNT=%0d want all 0",
                     dp_bus.DOUT, dp_bus.RF_DOUT, dp_bus.ZERO, dp_bus.CARRY, dp_bus.WR_CNT);
        end
        @(negedge CLK);
        dp_bus.CE = 4'b0000;
        RESET_N = 1'b1;
    endtask

    task automatic test_saturation();
        step(1'b1, 4'b0000, 3'd0, 2'b00, 3'b000, 8'h00, 8'h00);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 4'b1101, 3'(i % 8), 2'b00, 3'b000, 8'($urandom), 8'h00);
            n_tests++;
            if (int'(dp_bus.WR_CNT) != ((i + 1 > 15) ? 15 : i + 1)) begin
                n_fail++;
                $display("FAIL wr_cnt_sat[%0d]: WR_CNT=%0d want %0d",
                         i, dp_bus.WR_CNT, (i + 1 > 15) ? 15 : i + 1);
            end
        end
        for (int w = 0; w < 8; w++) begin
            step(1'b0, 4'b0000, 3'(w), 2'b00, 3'b000, 8'h00, 8'h00);
            n_tests++;
            if (dp_bus.RF_DOUT !== WIDTH'(m_rf[w])) begin
                n_fail++;
                $display("FAIL rf_sweep[%0d]: RF_DOUT=%h want %h", w, dp_bus.RF_DOUT, WIDTH'(m_rf[w]));
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 15) == 0), 4'($urandom), 3'($urandom), 2'($urandom),
                 3'($urandom), 8'($urandom), 8'($urandom));
            n_tests++;
            if (dp_bus.DOUT !== WIDTH'(m_rd) || dp_bus.ZERO !== 1'(m_zero) ||
                dp_bus.CARRY !== 1'(m_carry) || dp_bus.WR_CNT !== 4'(m_cnt) ||
                dp_bus.RF_DOUT !== WIDTH'(m_rf[dp_bus.W])) begin
                n_fail++;
                $display("FAIL random[%0d]: DOUT=%h Z=%b C=%b CNT=%0d RF=%h want %h/%0d/%0d/%0d/%h",
                         i, dp_bus.DOUT, dp_bus.ZERO, dp_bus.CARRY, dp_bus.WR_CNT, dp_bus.RF_DOUT,
                         WIDTH'(m_rd), m_zero, m_carry, m_cnt, WIDTH'(m_rf[dp_bus.W]));
            end
        end
    endtask

    initial begin
        test_reset();
        test_standard_pass();
        test_borrow_zero();
        test_simultaneous();
        test_clr();
        test_async_reset();
        test_saturation();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
